// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment display controller: scan prescaler, sequential double-dabble
// binary-to-BCD conversion, leading-zero blanking, per-digit decimal points, overflow dashes.
module fnd_scan_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned VALUE_W  = 14,
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_onOff,
    input  logic                i_load,
    input  logic [VALUE_W-1:0]  i_value,
    input  logic [N_DIGITS-1:0] i_dp,
    input  logic                i_blank_lz,
    output logic [7:0]          o_font,
    output logic [N_DIGITS-1:0] o_digit,
    output logic                o_busy,
    output logic                o_overflow
);

    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        for (int unsigned i = 0; i < 12; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [7:0] f;
        case (d)
            4'd0: f = 8'hC0;
            4'd1: f = 8'hF9;
            4'd2: f = 8'hA4;
            4'd3: f = 8'hB0;
            4'd4: f = 8'h99;
            4'd5: f = 8'h92;
            4'd6: f = 8'h82;
            4'd7: f = 8'hF8;
            4'd8: f = 8'h80;
            4'd9: f = 8'h90;
            default: f = 8'hFF;
        endcase
        return f[6:0];
    endfunction

    localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
    localparam int unsigned PRE_W  = $clog2(DIV);
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned ITER_W = $clog2(VALUE_W + 1);
    localparam int unsigned DEC_N  = dec_digits(VALUE_W);
    localparam int unsigned BCD_N  = (DEC_N > N_DIGITS) ? DEC_N : N_DIGITS;
    localparam int unsigned BCD_W  = 4 * BCD_N;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic                    scan_tick;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VALUE_W-1:0]      val_q, val_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [BCD_W-1:0]        sh_q, sh_d, sh_adj;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              font_q, font_d;
    logic [N_DIGITS-1:0]     digit_q, digit_d;
    logic [N_DIGITS-1:0]     zero_from;
    logic                    run_zero;
    logic [3:0]              nib;
    logic                    dp_lit, blank;
    logic [6:0]              seg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (i_load) state_d = S_SHIFT;
                S_SHIFT: if (iter_q == ITER_W'(VALUE_W - 1)) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (state_q != S_IDLE);
    end

    always_comb begin
        sh_adj = sh_q;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (sh_q[4*i +: 4] >= 4'd5) sh_adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        scan_tick = (pre_q == PRE_W'(DIV - 1));
        pre_d     = scan_tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        if (scan_tick) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        val_d  = val_q;
        iter_d = iter_q;
        sh_d   = sh_q;
        disp_d = disp_q;
        ovf_d  = ovf_q;
        case (state_q)
            S_IDLE: if (i_load) begin
                val_d  = i_value;
                iter_d = '0;
                sh_d   = '0;
            end
            S_SHIFT: begin
                sh_d   = (sh_adj << 1) | BCD_W'(val_q[VALUE_W-1]);
                val_d  = val_q << 1;
                iter_d = iter_q + 1'b1;
            end
            S_DONE: begin
                disp_d = sh_q[4*N_DIGITS-1:0];
                ovf_d  = |(sh_q >> (4 * N_DIGITS));
            end
            default: ;
        endcase
        if (i_clear) begin
            pre_d  = '0;
            idx_d  = '0;
            val_d  = '0;
            iter_d = '0;
            sh_d   = '0;
            disp_d = '0;
            ovf_d  = 1'b0;
        end
    end

    // Outputs are registered from next-state values so digit enable and font switch on the same edge.
    always_comb begin
        run_zero  = 1'b1;
        zero_from = '0;
        for (int unsigned k = N_DIGITS; k > 0; k--) begin
            run_zero       = run_zero & (disp_d[4*(k-1) +: 4] == 4'd0);
            zero_from[k-1] = run_zero;
        end
        nib     = '0;
        dp_lit  = 1'b0;
        blank   = 1'b0;
        digit_d = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib        = disp_d[4*k +: 4];
                dp_lit     = i_dp[k];
                blank      = i_blank_lz && (k != 0) && zero_from[k];
                digit_d[k] = 1'b0;
            end
        end
        seg    = ovf_d ? 7'h3F : (blank ? 7'h7F : seg7(nib));
        font_d = {~dp_lit, seg};
        if (i_clear || !i_onOff) begin
            font_d  = 8'hFF;
            digit_d = '1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            iter_q  <= '0;
            sh_q    <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            font_q  <= 8'hFF;
            digit_q <= '1;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            iter_q  <= iter_d;
            sh_q    <= sh_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            font_q  <= font_d;
            digit_q <= digit_d;
        end
    end

    assign o_font     = font_q;
    assign o_digit    = digit_q;
    assign o_overflow = ovf_q;

endmodule
